ifu_ctrl: RTL and testbench

//  Sequencing controller for the integer functional unit (ALU + MU + QRU) of the RV32IM datapath.

---
 rtl/ifu_ctrl.sv | 129 ++++++++++++
 tb/tb_ifu_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ifu_ctrl.sv
// ifu_ctrl: RV32IM integer-unit sequencer (ALU/MU/QRU control, PC stall, writeback); optional IFU_DIV_TIMEOUT_EN
//  ports: clk, rst (async, active-high) | opcode, func3, func7b5, func7b0, div_done in
//         pc_en, pcctl, regwe, aluctl, mulctl, divctl, div_start, ifuresctl, busy, illegal out
module ifu_ctrl #(
  parameter int MUL_LAT     = 2,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       func7b5,
  input  logic       func7b0,
  input  logic       div_done,
  output logic       pc_en,
  output logic       pcctl,
  output logic       regwe,
  output logic [3:0] aluctl,
  output logic [1:0] mulctl,
  output logic [1:0] divctl,
  output logic       div_start,
  output logic [1:0] ifuresctl,
  output logic       busy,
  output logic       illegal
);
  localparam int CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  typedef enum logic [1:0] {EXEC, MUL_WAIT, DIV_WAIT} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [1:0] r_mulctl, r_divctl;
  logic w_rv, w_mul, w_div, w_alu_ok, w_alu_legal, w_tmo;
  logic [3:0] w_alu;
  assign w_rv        = opcode == 7'b0110011;
  assign w_mul       = w_rv & func7b0 & ~func3[2];
  assign w_div       = w_rv & func7b0 & func3[2];
  assign w_alu_legal = w_rv & ~func7b0 & w_alu_ok;
  // func7b5 only selects SUB/SRA; on any other func3 it makes the instruction illegal
  always_comb begin
    w_alu    = 4'd0;
    w_alu_ok = ~func7b5;
    case (func3)
      3'b000: begin w_alu = func7b5 ? 4'd1 : 4'd0; w_alu_ok = 1'b1; end
      3'b001: w_alu = 4'd5;
      3'b010: w_alu = 4'd8;
      3'b011: w_alu = 4'd9;
      3'b100: w_alu = 4'd4;
      3'b101: begin w_alu = func7b5 ? 4'd7 : 4'd6; w_alu_ok = 1'b1; end
      3'b110: w_alu = 4'd3;
      default: w_alu = 4'd2;
    endcase
  end
`ifdef IFU_DIV_TIMEOUT_EN
  logic [7:0] r_tcnt;
  assign w_tmo = r_tcnt == 8'(DIV_TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_tcnt <= 8'd0;
    else     r_tcnt <= (r_state == DIV_WAIT) ? r_tcnt + 8'd1 : 8'd0;
`else
  assign w_tmo = 1'b0;
`endif
  // op fields are captured while issuing so wait states ignore datapath glitches
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state  <= EXEC;
      r_cnt    <= '0;
      r_mulctl <= 2'd0;
      r_divctl <= 2'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == EXEC) ? CW'(MUL_LAT - 1) : r_cnt - 1'b1;
      if (r_state == EXEC) begin
        r_mulctl <= func3[1:0];
        r_divctl <= func3[1:0];
      end
    end
  // everything is forced low while rst is high, including the decoded EXEC outputs
  always_comb begin
    w_next    = r_state;
    pc_en     = 1'b0;
    pcctl     = 1'b0;
    regwe     = 1'b0;
    aluctl    = 4'd0;
    mulctl    = 2'd0;
    divctl    = 2'd0;
    div_start = 1'b0;
    ifuresctl = 2'd0;
    busy      = 1'b0;
    illegal   = 1'b0;
    if (!rst) begin
      aluctl = w_alu;
      busy   = r_state != EXEC;
      case (r_state)
        EXEC: begin
          mulctl = func3[1:0];
          divctl = func3[1:0];
          if (w_mul) begin
            ifuresctl = 2'd1;
            regwe     = MUL_LAT == 1;
            pc_en     = MUL_LAT == 1;
            w_next    = (MUL_LAT == 1) ? EXEC : MUL_WAIT;
          end else if (w_div) begin
            div_start = 1'b1;
            w_next    = DIV_WAIT;
          end else begin
            illegal = ~w_alu_legal;
            regwe   = w_alu_legal;
            pc_en   = 1'b1;
          end
        end
        MUL_WAIT: begin
          mulctl    = r_mulctl;
          ifuresctl = 2'd1;
          regwe     = r_cnt == CW'(1);
          pc_en     = r_cnt == CW'(1);
          w_next    = (r_cnt == CW'(1)) ? EXEC : MUL_WAIT;
        end
        DIV_WAIT: begin
          divctl    = r_divctl;
          ifuresctl = 2'd2;
          regwe     = div_done;
          illegal   = ~div_done & w_tmo;
          pc_en     = div_done | w_tmo;
          w_next    = (div_done | w_tmo) ? EXEC : DIV_WAIT;
        end
        default: w_next = EXEC;
      endcase
    end
  end
endmodule

// File: tb/tb_ifu_ctrl.sv
// tb_ifu_ctrl: directed checks of ifu_ctrl with MUL_LAT=2 (dut a) and MUL_LAT=4 (dut b)
module tb_ifu_ctrl;
  localparam logic [6:0] OP = 7'b0110011;
  localparam int AF3[10] = '{0, 0, 7, 6, 4, 1, 5, 5, 2, 3};
  localparam int AB5[10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] func3 = 3'd0;
  logic func7b5 = 1'b0, func7b0 = 1'b0, div_done = 1'b0;
  logic pc_en_a, pcctl_a, regwe_a, div_start_a, busy_a, illegal_a;
  logic [3:0] aluctl_a;
  logic [1:0] mulctl_a, divctl_a, ifuresctl_a;
  logic pc_en_b, pcctl_b, regwe_b, div_start_b, busy_b, illegal_b;
  logic [3:0] aluctl_b;
  logic [1:0] mulctl_b, divctl_b, ifuresctl_b;
  int n_pass = 0, n_tot = 0;
  wire [6:0] o_a = {pc_en_a, regwe_a, busy_a, illegal_a, div_start_a, ifuresctl_a};
  wire [6:0] o_b = {pc_en_b, regwe_b, busy_b, illegal_b, div_start_b, ifuresctl_b};
  wire [31:0] all_out = {o_a, o_b, aluctl_a, aluctl_b, mulctl_a, mulctl_b, divctl_a, divctl_b, pcctl_a, pcctl_b};
  ifu_ctrl #(.MUL_LAT(2), .DIV_TIMEOUT(8)) u_a (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7b5(func7b5), .func7b0(func7b0),
    .div_done(div_done), .pc_en(pc_en_a), .pcctl(pcctl_a), .regwe(regwe_a), .aluctl(aluctl_a),
    .mulctl(mulctl_a), .divctl(divctl_a), .div_start(div_start_a), .ifuresctl(ifuresctl_a),
    .busy(busy_a), .illegal(illegal_a));
  ifu_ctrl #(.MUL_LAT(4), .DIV_TIMEOUT(8)) u_b (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7b5(func7b5), .func7b0(func7b0),
    .div_done(div_done), .pc_en(pc_en_b), .pcctl(pcctl_b), .regwe(regwe_b), .aluctl(aluctl_b),
    .mulctl(mulctl_b), .divctl(divctl_b), .div_start(div_start_b), .ifuresctl(ifuresctl_b),
    .busy(busy_b), .illegal(illegal_b));
  always #5 clk = ~clk;
  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic b5, input logic b0);
    opcode = op; func3 = f3; func7b5 = b5; func7b0 = b0;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic reset_duts;
    rst = 1'b1;
    instr(OP, 3'd0, 1'b0, 1'b0);
    div_done = 1'b0;
    tick;
    rst = 1'b0;
  endtask
  task automatic test_reset;
    instr(OP, 3'd0, 1'b0, 1'b0);
    #2;
    n_tot++;
    if (all_out !== 32'd0) $display("FAIL reset_outputs got=%h exp=0", all_out); else n_pass++;
    tick;
    n_tot++;
    if (all_out !== 32'd0) $display("FAIL reset_held got=%h exp=0", all_out); else n_pass++;
    rst = 1'b0;
  endtask
  task automatic test_alu;
    for (int i = 0; i < 10; i++) begin
      instr(OP, 3'(AF3[i]), AB5[i][0], 1'b0);
      @(negedge clk);
      n_tot++;
      if ({o_a, aluctl_a} !== {7'b1100000, 4'(i)})
        $display("FAIL alu_%0d got=%b_%0d exp=1100000_%0d", i, o_a, aluctl_a, i);
      else n_pass++;
      tick;
    end
  endtask
  task automatic test_back_to_back;
    instr(OP, 3'b000, 1'b1, 1'b0);
    @(negedge clk);
    n_tot++;
    if ({pc_en_a, regwe_a, aluctl_a} !== 6'b11_0001) $display("FAIL b2b_sub got=%b exp=110001", {pc_en_a, regwe_a, aluctl_a}); else n_pass++;
    tick;
    instr(OP, 3'b101, 1'b1, 1'b0);
    @(negedge clk);
    n_tot++;
    if ({pc_en_a, regwe_a, aluctl_a} !== 6'b11_0111) $display("FAIL b2b_sra got=%b exp=110111", {pc_en_a, regwe_a, aluctl_a}); else n_pass++;
    tick;
  endtask
  task automatic test_illegal;
    instr(7'b0010011, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    n_tot++;
    if (o_a !== 7'b1001000) $display("FAIL illegal_opcode got=%b exp=1001000", o_a); else n_pass++;
    tick;
    instr(OP, 3'b001, 1'b1, 1'b0);
    @(negedge clk);
    n_tot++;
    if (o_a !== 7'b1001000) $display("FAIL illegal_f7b5 got=%b exp=1001000", o_a); else n_pass++;
    tick;
  endtask
  task automatic test_mul;
    reset_duts;
    instr(OP, 3'b000, 1'b0, 1'b1);
    @(negedge clk);
    n_tot++;
    if (o_a[6:2] !== 5'b00000) $display("FAIL mul_issue got=%b exp=00000", o_a[6:2]); else n_pass++;
    tick;
    @(negedge clk);
    n_tot++;
    if ({o_a, mulctl_a} !== 9'b1110001_00) $display("FAIL mul_retire got=%b exp=111000100", {o_a, mulctl_a}); else n_pass++;
    tick;
    reset_duts;
    instr(OP, 3'b011, 1'b0, 1'b1);
    @(negedge clk);
    n_tot++;
    if (o_b[6:2] !== 5'b00000) $display("FAIL mulhu_issue got=%b exp=00000", o_b[6:2]); else n_pass++;
    tick;
    func3 = 3'b000;
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      n_tot++;
      if ({o_b, mulctl_b} !== 9'b0010001_11) $display("FAIL mulhu_wait%0d got=%b exp=001000111", c, {o_b, mulctl_b}); else n_pass++;
      tick;
    end
    @(negedge clk);
    n_tot++;
    if ({o_b, mulctl_b} !== 9'b1110001_11) $display("FAIL mulhu_retire got=%b exp=111000111", {o_b, mulctl_b}); else n_pass++;
    tick;
  endtask
  task automatic test_div;
    reset_duts;
    instr(OP, 3'b110, 1'b0, 1'b1);
    @(negedge clk);
    n_tot++;
    if ({o_a[6:2], divctl_a} !== 7'b00001_10) $display("FAIL rem_issue got=%b exp=0000110", {o_a[6:2], divctl_a}); else n_pass++;
    tick;
    func3 = 3'b100;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      n_tot++;
      if ({o_a, divctl_a} !== 9'b0010010_10) $display("FAIL rem_wait%0d got=%b exp=001001010", c, {o_a, divctl_a}); else n_pass++;
      tick;
    end
    div_done = 1'b1;
    @(negedge clk);
    n_tot++;
    if ({o_a, divctl_a} !== 9'b1110010_10) $display("FAIL rem_retire got=%b exp=111001010", {o_a, divctl_a}); else n_pass++;
    tick;
    div_done = 1'b0;
    instr(OP, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    n_tot++;
    if (o_a !== 7'b1100000) $display("FAIL rem_after got=%b exp=1100000", o_a); else n_pass++;
    tick;
    instr(7'b0010011, 3'b000, 1'b0, 1'b0);
    div_done = 1'b1;
    @(negedge clk);
    n_tot++;
    if (o_a !== 7'b1001000) $display("FAIL stray_done got=%b exp=1001000", o_a); else n_pass++;
    tick;
    div_done = 1'b0;
  endtask
  task automatic test_rst_mid_div;
    reset_duts;
    instr(OP, 3'b100, 1'b0, 1'b1);
    tick;
    tick;
    tick;
    #2;
    rst = 1'b1;
    #1;
    n_tot++;
    if (all_out !== 32'd0) $display("FAIL rst_mid_div got=%h exp=0", all_out); else n_pass++;
    tick;
    rst = 1'b0;
    instr(7'b0000000, 3'b000, 1'b0, 1'b0);
    div_done = 1'b1;
    @(negedge clk);
    n_tot++;
    if ({o_a, regwe_b, busy_b} !== 9'b1001000_00) $display("FAIL late_done got=%b exp=100100000", {o_a, regwe_b, busy_b}); else n_pass++;
    tick;
    div_done = 1'b0;
  endtask
  task automatic test_div_timeout;
    reset_duts;
    instr(OP, 3'b101, 1'b0, 1'b1);
    tick;
`ifdef IFU_DIV_TIMEOUT_EN
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      n_tot++;
      if (o_a !== 7'b0010010) $display("FAIL tmo_wait%0d got=%b exp=0010010", c, o_a); else n_pass++;
      tick;
    end
    @(negedge clk);
    n_tot++;
    if (o_a !== 7'b1011010) $display("FAIL tmo_fire got=%b exp=1011010", o_a); else n_pass++;
    tick;
    instr(OP, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    n_tot++;
    if (o_a !== 7'b1100000) $display("FAIL tmo_after got=%b exp=1100000", o_a); else n_pass++;
`else
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      n_tot++;
      if (o_a !== 7'b0010010) $display("FAIL div_hold%0d got=%b exp=0010010", c, o_a); else n_pass++;
      tick;
    end
`endif
    reset_duts;
  endtask
  initial begin
    test_reset;
    test_alu;
    test_back_to_back;
    test_illegal;
    test_mul;
    test_div;
    test_rst_mid_div;
    test_div_timeout;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
